// File: rtl/vec_alu_sequencer.sv
// Command sequencer in front of the vector ALU: accepts one command, holds the
// registered operands for the opcode's latency, then returns the lane-masked result.
module vec_alu_sequencer #(
  parameter int LANES     = 16,
  parameter int WIDTH     = 16,
  parameter int BASIC_LAT = 1,
  parameter int MUL_LAT   = 2,
  parameter int DIV_LAT   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [2:0]                         cmd_op,
  input  logic [LANES-1:0][WIDTH-1:0]        cmd_a,
  input  logic [LANES-1:0][WIDTH-1:0]        cmd_b,
  input  logic [$clog2(LANES+1)-1:0]         cmd_vlen,
  output logic [LANES-1:0][WIDTH-1:0]        alu_a,
  output logic [LANES-1:0][WIDTH-1:0]        alu_b,
  output logic [2:0]                         alu_op,
  input  logic [LANES-1:0][WIDTH-1:0]        alu_result,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [LANES-1:0][WIDTH-1:0]        rsp_data,
  output logic                               rsp_err,
  output logic                               rsp_divz,
  output logic                               busy
);

  localparam int VLEN_W  = $clog2(LANES + 1);
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT)
                           ? ((DIV_LAT > BASIC_LAT) ? DIV_LAT : BASIC_LAT)
                           : ((MUL_LAT > BASIC_LAT) ? MUL_LAT : BASIC_LAT);
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                      state, state_nxt;
  logic                        accept;
  logic                        capture;
  logic                        rsp_hs;
  logic [CNT_W-1:0]            counter;
  logic [CNT_W-1:0]            lat_load;
  logic [VLEN_W-1:0]           vlen_clamp;
  logic [VLEN_W-1:0]           vlen_q;
  logic                        err_q;
  logic                        divz_q;
  logic                        divz_nxt;
  logic [LANES-1:0][WIDTH-1:0] masked_result;

  // Ready does not look at cmd_valid, so a source may wait on it without a loop.
  assign cmd_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign capture   = (state == EXEC) && (counter == '0);
  assign rsp_hs    = (state == RESP) && rsp_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: if (counter == '0) state_nxt = RESP;
      RESP: if (rsp_hs) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lat_load = '0;
    case (cmd_op)
      OP_ADD, OP_SUB, OP_MOV: lat_load = CNT_W'(BASIC_LAT - 1);
      OP_MUL:                 lat_load = CNT_W'(MUL_LAT - 1);
      OP_DIV:                 lat_load = CNT_W'(DIV_LAT - 1);
      default:                lat_load = '0;
    endcase
  end

  always_comb begin
    vlen_clamp = (cmd_vlen > VLEN_W'(LANES)) ? VLEN_W'(LANES) : cmd_vlen;
    divz_nxt   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if ((cmd_op == OP_DIV) && (VLEN_W'(i) < vlen_clamp) && (cmd_b[i] == '0))
        divz_nxt = 1'b1;
    end
  end

  // Illegal opcodes return an all-zero vector regardless of what the ALU drives.
  always_comb begin
    masked_result = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!err_q && (VLEN_W'(i) < vlen_q))
        masked_result[i] = alu_result[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands change only on accept, so the ALU sees stable inputs for the whole EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= OP_MOV;
      vlen_q <= '0;
      err_q  <= 1'b0;
      divz_q <= 1'b0;
    end else if (accept) begin
      alu_a  <= cmd_a;
      alu_b  <= cmd_b;
      alu_op <= cmd_op;
      vlen_q <= vlen_clamp;
      err_q  <= (cmd_op > OP_DIV);
      divz_q <= divz_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= '0;
    end else if (accept) begin
      counter <= lat_load;
    end else if ((state == EXEC) && (counter != '0)) begin
      counter <= counter - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_divz  <= 1'b0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= masked_result;
      rsp_err   <= err_q;
      rsp_divz  <= divz_q;
    end else if (rsp_hs) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Self-checking bench for vec_alu_sequencer: an ALU stub drives alu_result and a
// command-level reference model predicts data, flags and latency.
module tb_vec_alu_sequencer;

  typedef logic [15:0][15:0] vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  vec_t       cmd_a = '0;
  vec_t       cmd_b = '0;
  logic [4:0] cmd_vlen = '0;
  vec_t       alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  vec_t       rsp_data;
  logic       rsp_err, rsp_divz, busy;

  int checks = 0;
  int errors = 0;

  vec_alu_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_vlen(cmd_vlen),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_divz(rsp_divz), .busy(busy)
  );

  always #5 clk = ~clk;

  // Per-lane ALU arithmetic; divide by zero yields all ones, illegal ops yield junk.
  function automatic logic [15:0] lane_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] t;
    case (op)
      3'd0: t = 32'(a) + 32'(b);
      3'd1: t = 32'(a) - 32'(b);
      3'd2: t = 32'(a);
      3'd3: t = 32'(a) * 32'(b);
      3'd4: t = (b == 16'd0) ? 32'hFFFF : 32'(a / b);
      default: t = 32'hDEAD;
    endcase
    return t[15:0];
  endfunction

  always_comb begin
    alu_result = '0;
    for (int i = 0; i < 16; i++) alu_result[i] = lane_op(alu_op, alu_a[i], alu_b[i]);
  end

  // Reference model at command level, computed from the command as issued.
  function automatic vec_t model_data(input logic [2:0] op, input vec_t a, input vec_t b, input int vlen);
    vec_t r = '0;
    int vl = (vlen > 16) ? 16 : vlen;
    for (int i = 0; i < vl; i++) if (op <= 3'd4) r[i] = lane_op(op, a[i], b[i]);
    return r;
  endfunction

  function automatic logic model_divz(input logic [2:0] op, input vec_t b, input int vlen);
    int vl = (vlen > 16) ? 16 : vlen;
    if (op != 3'd4) return 1'b0;
    for (int i = 0; i < vl; i++) if (b[i] == 16'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_lat(input logic [2:0] op);
    case (op)
      3'd3: return 2;
      3'd4: return 4;
      default: return 1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [2:0] op, input vec_t a, input vec_t b, input int vlen);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_vlen  = 5'(vlen);
    cmd_valid = 1'b1;
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (cmd_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 30) begin
      tick();
      cycles++;
    end
    if (!rsp_valid) cycles = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (alu_op !== 3'b010) begin errors++; $display("FAIL reset_alu_op: got %b expected 010", alu_op); end
    checks++; if (alu_a !== '0 || alu_b !== '0) begin errors++; $display("FAIL reset_alu_ab: got %h/%h expected 0", alu_a, alu_b); end
    checks++; if (rsp_data !== '0 || rsp_err !== 1'b0 || rsp_divz !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %h err %b divz %b expected zeros", rsp_data, rsp_err, rsp_divz); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    vec_t a = '0, b = '0, exp;
    int   cyc;
    bit   ok;
    int   av[8] = '{200, 254, 251, 200, 5, 10, 100, 15};
    int   bv[8] = '{100, 1, 1, 45, 25, 1, 2, 10};
    for (int i = 0; i < 8; i++) begin a[i] = 16'(av[i]); b[i] = 16'(bv[i]); end
    a[15] = 16'hFFFF; b[15] = 16'd1;
    exp = model_data(3'd0, a, b, 16);
    rsp_ready = 1'b1;
    drive_cmd(3'd0, a, b, 16);
    wait_accept(ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_accept: got no accept expected accept"); end
    checks++; if (alu_a !== a || alu_op !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL add_alu_regs: got op %b busy %b expected op 000 busy 1", alu_op, busy); end
    wait_rsp(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", cyc); end
    checks++; if (rsp_data !== exp) begin errors++; $display("FAIL add_data: got %h expected %h", rsp_data, exp); end
    checks++; if (rsp_data[0] !== 16'd300 || rsp_data[3] !== 16'd245 || rsp_data[15] !== 16'd0) begin errors++; $display("FAIL add_lanes: got %0d/%0d/%0d expected 300/245/0", rsp_data[0], rsp_data[3], rsp_data[15]); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL add_err: got %b expected 0", rsp_err); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_drain: got valid %b busy %b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_back_to_back();
    vec_t a = '0, b = '0, a2 = '0, b2 = '0, exp;
    int   cyc;
    bit   ok;
    a[0] = 16'd2; a[1] = 16'd6; a[2] = 16'd10; a[3] = 16'd15;
    b[0] = 16'd2; b[1] = 16'd2; b[2] = 16'd20; b[3] = 16'd2;
    a2[0] = 16'd200; a2[1] = 16'd8; b2[0] = 16'd100; b2[1] = 16'd4;
    rsp_ready = 1'b1;
    drive_cmd(3'd3, a, b, 16);
    wait_accept(ok);
    wait_rsp(cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL mul_latency: got %0d expected 2", cyc); end
    exp = model_data(3'd3, a, b, 16);
    checks++; if (rsp_data !== exp || rsp_data[2] !== 16'd200) begin errors++; $display("FAIL mul_data: got %h expected %h", rsp_data, exp); end
    drive_cmd(3'd4, a2, b2, 2);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || alu_op !== 3'd4) begin errors++; $display("FAIL b2b_bubble: got valid %b busy %b op %b expected 0 1 100", rsp_valid, busy, alu_op); end
    wait_rsp(cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL div_latency: got %0d expected 4", cyc); end
    checks++; if (rsp_data[0] !== 16'd2 || rsp_data[1] !== 16'd2 || rsp_data !== model_data(3'd4, a2, b2, 2)) begin errors++; $display("FAIL div_data: got %h expected lanes 2,2", rsp_data); end
    checks++; if (rsp_divz !== 1'b0) begin errors++; $display("FAIL div_divz: got %b expected 0", rsp_divz); end
    tick();
  endtask

  task automatic test_mask_divz();
    vec_t a, b, exp;
    int   cyc;
    bit   ok;
    rsp_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        a[i] = 16'($urandom);
        b[i] = 16'($urandom_range(1, 255));
      end
      b[5] = 16'd0;
      if (pass == 0) b[1] = 16'd0;
      exp = model_data(3'd4, a, b, 3);
      drive_cmd(3'd4, a, b, 3);
      wait_accept(ok);
      wait_rsp(cyc);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL mask_latency_%0d: got %0d expected 4", pass, cyc); end
      checks++; if (rsp_divz !== (pass == 0)) begin errors++; $display("FAIL mask_divz_%0d: got %b expected %b", pass, rsp_divz, pass == 0); end
      checks++; if (rsp_data !== exp || rsp_data[15:3] !== '0) begin errors++; $display("FAIL mask_data_%0d: got %h expected %h", pass, rsp_data, exp); end
      tick();
    end
    // vlen 0 keeps latency and masks everything; vlen above LANES is clamped.
    for (int i = 0; i < 16; i++) begin a[i] = 16'($urandom); b[i] = 16'($urandom); end
    drive_cmd(3'd0, a, b, 0);
    wait_accept(ok);
    wait_rsp(cyc);
    checks++; if (cyc !== 1 || rsp_data !== '0) begin errors++; $display("FAIL vlen0: got lat %0d data %h expected 1 and 0", cyc, rsp_data); end
    tick();
    drive_cmd(3'd2, a, b, 25);
    wait_accept(ok);
    wait_rsp(cyc);
    checks++; if (rsp_data !== a) begin errors++; $display("FAIL vlen_clamp: got %h expected %h", rsp_data, a); end
    tick();
  endtask

  task automatic test_backpressure();
    vec_t a, b, held;
    int   cyc;
    bit   ok;
    for (int i = 0; i < 16; i++) begin a[i] = 16'($urandom); b[i] = 16'($urandom); end
    rsp_ready = 1'b0;
    drive_cmd(3'd1, a, b, 16);
    wait_accept(ok);
    wait_rsp(cyc);
    checks++; if (cyc !== 1 || rsp_data !== model_data(3'd1, a, b, 16)) begin errors++; $display("FAIL bp_sub: got lat %0d data %h", cyc, rsp_data); end
    held = rsp_data;
    drive_cmd(3'd0, b, a, 16);
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 || alu_op !== 3'd1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid %b ready %b op %b expected 1 0 001 with data held", n, rsp_valid, cmd_ready, alu_op);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || alu_op !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL bp_accept: got valid %b op %b busy %b expected 0 000 1", rsp_valid, alu_op, busy); end
    wait_rsp(cyc);
    checks++; if (cyc !== 1 || rsp_data !== model_data(3'd0, b, a, 16)) begin errors++; $display("FAIL bp_add: got lat %0d data %h", cyc, rsp_data); end
    tick();
  endtask

  task automatic test_illegal();
    vec_t a, b;
    int   cyc;
    bit   ok;
    for (int i = 0; i < 16; i++) begin a[i] = 16'($urandom); b[i] = 16'(i); end
    rsp_ready = 1'b1;
    drive_cmd(3'b110, a, b, 16);
    wait_accept(ok);
    wait_rsp(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL illegal_latency: got %0d expected 1", cyc); end
    checks++; if (rsp_err !== 1'b1 || rsp_data !== '0 || rsp_divz !== 1'b0) begin errors++; $display("FAIL illegal_rsp: got err %b data %h divz %b expected 1 0 0", rsp_err, rsp_data, rsp_divz); end
    tick();
    drive_cmd(3'd0, a, b, 16);
    wait_accept(ok);
    wait_rsp(cyc);
    checks++; if (rsp_err !== 1'b0 || rsp_data !== model_data(3'd0, a, b, 16)) begin errors++; $display("FAIL illegal_next_add: got err %b data %h", rsp_err, rsp_data); end
    tick();
  endtask

  task automatic test_random();
    vec_t       a, b, exp, held;
    logic [2:0] op;
    int         vlen, hold, cyc;
    bit         ok;
    for (int n = 0; n < 40; n++) begin
      op   = 3'($urandom_range(0, 7));
      vlen = $urandom_range(0, 20);
      hold = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) begin
        a[i] = 16'($urandom);
        b[i] = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      end
      exp = model_data(op, a, b, vlen);
      rsp_ready = (hold == 0);
      drive_cmd(op, a, b, vlen);
      wait_accept(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_accept_%0d: got no accept expected accept", n); end
      wait_rsp(cyc);
      checks++;
      if (cyc !== model_lat(op) || rsp_data !== exp || rsp_err !== (op > 3'd4) || rsp_divz !== model_divz(op, b, vlen)) begin
        errors++;
        $display("FAIL rnd_rsp_%0d: op %0d vlen %0d got lat %0d err %b divz %b data %h expected lat %0d data %h",
                 n, op, vlen, cyc, rsp_err, rsp_divz, rsp_data, model_lat(op), exp);
      end
      held = rsp_data;
      for (int h = 0; h < hold; h++) begin
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== held) begin errors++; $display("FAIL rnd_hold_%0d: got valid %b data %h expected 1 %h", n, rsp_valid, rsp_data, held); end
      end
      rsp_ready = 1'b1;
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain_%0d: got %b expected 0", n, rsp_valid); end
    end
  endtask

  task automatic test_reset_mid();
    vec_t a, b;
    bit   ok, seen;
    for (int i = 0; i < 16; i++) begin a[i] = 16'($urandom); b[i] = 16'($urandom_range(1, 9)); end
    rsp_ready = 1'b1;
    drive_cmd(3'd4, a, b, 16);
    wait_accept(ok);
    tick();
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_op !== 3'b010 || alu_a !== '0) begin errors++; $display("FAIL reset_mid: got busy %b valid %b op %b expected 0 0 010", busy, rsp_valid, alu_op); end
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_stale_rsp: got response expected none"); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_after: got ready %b busy %b expected 1 0", cmd_ready, busy); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #2;
    test_reset();
    test_add();
    test_back_to_back();
    test_mask_divz();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_alu_sequencer.md
Name: vec_alu_sequencer

Overview:
- Command-level controller in front of the vector ALU (16 lanes x 16 bits; opcodes ADD=000, SUB=001, MOV=010, MUL=011, DIV=100).
- Accepts one vector command at a time from decode over a valid/ready handshake and registers the operands onto the ALU inputs.
- Holds the operands stable for the opcode's latency, then captures the result, masking lanes at or beyond the vector length.
- Returns the result on a valid/ready response channel to writeback.

Parameters:
- LANES, 16, number of vector lanes.
- WIDTH, 16, bits per lane.
- BASIC_LAT, 1, cycles the ALU needs for ADD/SUB/MOV (minimum 1).
- MUL_LAT, 2, cycles for MUL (minimum 1).
- DIV_LAT, 4, cycles for DIV (minimum 1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command this cycle.
- cmd_op  in  3  opcode.
- cmd_a  in  LANES x WIDTH  operand vector A.
- cmd_b  in  LANES x WIDTH  operand vector B.
- cmd_vlen  in  clog2(LANES+1)  active lane count, 0..LANES.
- alu_a  out  LANES x WIDTH  registered operand A to the ALU.
- alu_b  out  LANES x WIDTH  registered operand B to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- alu_result  in  LANES x WIDTH  ALU output (combinational from alu_a/alu_b/alu_op).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  writeback accepts the response.
- rsp_data  out  LANES x WIDTH  masked result.
- rsp_err  out  1  illegal opcode (101..111).
- rsp_divz  out  1  DIV issued with B==0 in some active lane.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; alu_a, alu_b, rsp_data = 0; alu_op=010 (MOV); counter=0; rsp_valid, rsp_err, rsp_divz, busy = 0.
- States and transitions:
  - IDLE -> EXEC on accept.
  - EXEC -> RESP when counter==0.
  - RESP -> IDLE on response handshake with no new accept.
  - RESP -> EXEC on response handshake together with a new accept.
- cmd_ready = (state==IDLE) | (state==RESP & rsp_ready); combinational, does not depend on cmd_valid.
- Accept = cmd_valid & cmd_ready. At the accepting edge:
  - alu_a/alu_b/alu_op <= cmd_*; vlen_q <= min(cmd_vlen, LANES).
  - counter <= LAT-1, where LAT is BASIC_LAT, MUL_LAT or DIV_LAT by opcode; illegal opcodes use 0.
  - err_q <= (cmd_op > 100).
  - divz_q <= (cmd_op==100) & OR over active lanes i<vlen of (cmd_b[i]==0).
- EXEC: if counter!=0, counter decrements. If counter==0, capture at the next edge:
  - rsp_data[i] <= (i < vlen_q) ? alu_result[i] : 0; rsp_data <= 0 entirely when err_q.
  - rsp_err <= err_q; rsp_divz <= divz_q; rsp_valid <= 1.
- Latency from accepting edge to rsp_valid high: LAT edges. ADD lands 1 cycle later, MUL 2, DIV 4, illegal 1.
- Arithmetic is owned by the ALU. The sequencer never modifies lane values other than masking; results are WIDTH bits, truncated by the ALU (wrap, e.g. 65535+1=0).
- alu_a/alu_b/alu_op hold their values from accept until the next accept; they are never changed in EXEC.
- RESP: rsp_valid, rsp_data, rsp_err and rsp_divz are held stable until rsp_ready. On the handshake edge rsp_valid <= 0 unless a simultaneous accept occurs, in which case rsp_valid <= 0 and the new command enters EXEC (a single-cycle bubble minimum between responses).
- cmd_vlen=0: all lanes masked, rsp_data=0, latency unchanged, divz_q=0.
- cmd_valid during EXEC is ignored (cmd_ready=0) and must be held by the source.
- Reset asserted mid-EXEC or mid-RESP: the command is dropped, all outputs return to reset values immediately, and no response is produced.

Test Plan:
- ADD: A[0..7]={200,254,251,200,5,10,100,15}, B[0..7]={100,1,1,45,25,1,2,10}, vlen=16, rsp_ready=1 -> rsp_valid 1 cycle after accept; rsp_data[0..7]={300,255,252,245,30,11,102,25}; rsp_err=0.
- MUL then DIV back-to-back with rsp_ready=1:
  - MUL with A={2,6,10,15}, B={2,2,20,2} -> rsp 2 cycles after accept, data {4,12,200,30}.
  - DIV with A={200,8}, B={100,4} accepted on the MUL response handshake cycle -> rsp 4 cycles later, data {2,2}.
- Masking/divz: DIV, vlen=3, B[5]=0, B[1]=0 -> rsp_divz=1 (lane 1 active). Repeat with only B[5]=0 -> rsp_divz=0; rsp_data[3..15]=0.
- Backpressure: SUB result ready, hold rsp_ready=0 for 5 cycles with a new cmd_valid asserted -> rsp_data and rsp_valid stable, cmd_ready=0. Release rsp_ready -> new command accepted on the same edge.
- Illegal opcode 110 -> rsp_valid after 1 cycle, rsp_err=1, rsp_data=0. Next ADD proceeds normally with rsp_err=0.
- Reset: assert reset low 2 cycles into a DIV -> busy=0, rsp_valid=0, alu_op=010 immediately. After release, no stale response; cmd_ready=1.
